// File: rtl/ecc_ctrl_pkg.sv
// Shared definitions for the ECC scalar-multiplication sequencer:
// microword layout, op encodings and FSM states.
package ecc_ctrl_pkg;

  localparam int UW_W    = 44;
  localparam int CW_LSB  = 0;
  localparam int CW_W    = 33;
  localparam int OP_LSB  = 33;
  localparam int OP_W    = 3;
  localparam int ARG_LSB = 36;
  localparam int ARG_W   = 8;

  // Codes 5-7 are not listed and execute as OP_NEXT.
  typedef enum logic [OP_W-1:0] {
    OP_NEXT   = 3'd0,
    OP_BR_KEY = 3'd1,
    OP_LOOP   = 3'd2,
    OP_REP    = 3'd3,
    OP_HALT   = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  function automatic logic [UW_W-1:0] uword(input logic [OP_W-1:0] op,
                                            input logic [ARG_W-1:0] arg,
                                            input logic [CW_W-1:0] cw);
    return {arg, op, cw};
  endfunction

endpackage

// File: rtl/ecc_ucode_rom.sv
// Combinational microcode ROM; IMAGE 0 is the Montgomery-ladder program,
// the other images are small diagnostic programs with the same ports.
module ecc_ucode_rom
  import ecc_ctrl_pkg::*;
#(
  parameter int UPC_W = 8,
  parameter int IMAGE = 0
) (
  input  logic [UPC_W-1:0] addr,
  output logic [UW_W-1:0]  data
);

  always_comb begin
    data = uword(OP_NEXT, 8'd0, 33'd0);
    case (IMAGE)
      1: begin
        case (int'(addr))
          0:       data = uword(OP_NEXT, 8'd0, 33'h1);
          1:       data = uword(OP_NEXT, 8'd0, 33'h2);
          2:       data = uword(OP_NEXT, 8'd0, 33'h3);
          3:       data = uword(OP_HALT, 8'd0, 33'h0);
          default: ;
        endcase
      end
      2: begin
        case (int'(addr))
          0:       data = uword(OP_BR_KEY, 8'd10, 33'h10);
          1:       data = uword(OP_NEXT,   8'd0,  33'h11);
          2:       data = uword(OP_HALT,   8'd0,  33'h12);
          10:      data = uword(OP_NEXT,   8'd0,  33'h1A);
          11:      data = uword(OP_HALT,   8'd0,  33'h1B);
          default: ;
        endcase
      end
      3: begin
        case (int'(addr))
          0:       data = uword(OP_NEXT, 8'd0, 33'h20);
          1:       data = uword(OP_LOOP, 8'd0, 33'h21);
          2:       data = uword(OP_HALT, 8'd0, 33'h0);
          default: ;
        endcase
      end
      4: begin
        // Exercises REP, the unlisted op codes and the wrap from the top address.
        case (int'(addr))
          0:       data = uword(OP_REP,  8'd6,  33'h155);
          1:       data = uword(3'd5,    8'd0,  33'h1_0000_0001);
          2:       data = uword(3'd6,    8'd0,  33'h0_AAAA_5555);
          3:       data = uword(3'd7,    8'd0,  33'h3);
          4:       data = uword(OP_NEXT, 8'd0,  33'h4);
          5:       data = uword(OP_NEXT, 8'd0,  33'h5);
          6:       data = uword(OP_LOOP, 8'd15, 33'h6);
          7:       data = uword(OP_HALT, 8'd0,  33'h1_FFFF_FFFF);
          15:      data = uword(OP_NEXT, 8'd0,  33'h1F);
          default: ;
        endcase
      end
      default: begin
        // One ladder step per key bit: test the bit, run the add/double pair
        // on the matching branch, then step down to the next bit.
        case (int'(addr))
          0:       data = uword(OP_NEXT,   8'd0, 33'h0_0000_0013);
          1:       data = uword(OP_BR_KEY, 8'd5, 33'h0_0000_0100);
          2:       data = uword(OP_REP,    8'd3, 33'h0_0004_2001);
          3:       data = uword(OP_LOOP,   8'd1, 33'h0_0000_0200);
          4:       data = uword(OP_HALT,   8'd0, 33'h0);
          5:       data = uword(OP_REP,    8'd3, 33'h0_0008_1002);
          6:       data = uword(OP_LOOP,   8'd1, 33'h0_0000_0400);
          7:       data = uword(OP_NEXT,   8'd0, 33'h1_0000_0800);
          8:       data = uword(OP_HALT,   8'd0, 33'h0);
          default: ;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/ecc_ctrl_seq.sv
// Microcoded sequencer for ECC scalar multiplication: walks the key from the
// top bit down, issuing 33-bit control words to the register bank.
module ecc_ctrl_seq
  import ecc_ctrl_pkg::*;
#(
  parameter int KEY_W     = 233,
  parameter int UPC_W     = 8,
  parameter int ROM_IMAGE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KEY_W-1:0] key,
  output logic [32:0]      cword,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;

  state_e            state_q, state_d;
  logic [KEY_W-1:0]  key_r;
  logic [UPC_W-1:0]  upc_q, upc_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [7:0]        rep_cnt_q, rep_cnt_d;
  logic [UW_W-1:0]   mword;
  logic [CW_W-1:0]   cw;
  logic [OP_W-1:0]   op;
  logic [ARG_W-1:0]  arg;
  logic [UPC_W-1:0]  upc_inc;
  logic [UPC_W-1:0]  upc_arg;
  logic              accept;

  ecc_ucode_rom #(
    .UPC_W (UPC_W),
    .IMAGE (ROM_IMAGE)
  ) u_rom (
    .addr (upc_q),
    .data (mword)
  );

  assign cw      = mword[CW_LSB +: CW_W];
  assign op      = mword[OP_LSB +: OP_W];
  assign arg     = mword[ARG_LSB +: ARG_W];
  assign upc_inc = upc_q + UPC_W'(1);
  assign upc_arg = UPC_W'(arg);
  assign accept  = (state_q == ST_IDLE) && start;

  always_comb begin
    state_d   = state_q;
    upc_d     = upc_q;
    bit_idx_d = bit_idx_q;
    rep_cnt_d = rep_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          upc_d     = '0;
          bit_idx_d = IDX_W'(KEY_W - 1);
          rep_cnt_d = '0;
        end
      end
      ST_RUN: begin
        case (op)
          OP_HALT:   state_d = ST_FIN;
          OP_BR_KEY: upc_d = key_r[bit_idx_q] ? upc_arg : upc_inc;
          OP_LOOP: begin
            if (bit_idx_q != '0) begin
              bit_idx_d = bit_idx_q - IDX_W'(1);
              upc_d     = upc_arg;
            end else begin
              upc_d = upc_inc;
            end
          end
          OP_REP: begin
            // rep_cnt reaching arg marks the last of the arg+1 issues
            if (rep_cnt_q == arg) begin
              rep_cnt_d = '0;
              upc_d     = upc_inc;
            end else begin
              rep_cnt_d = rep_cnt_q + 8'd1;
            end
          end
          default:   upc_d = upc_inc;
        endcase
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      key_r     <= '0;
      upc_q     <= '0;
      bit_idx_q <= '0;
      rep_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      upc_q     <= upc_d;
      bit_idx_q <= bit_idx_d;
      rep_cnt_q <= rep_cnt_d;
      if (accept) key_r <= key;
    end
  end

  // Bank write-enables live in cword, so it must stay zero outside RUN and on HALT.
  assign cword = (state_q == ST_RUN && op != OP_HALT) ? cw : '0;
  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_FIN);

endmodule

// File: tb/tb_ecc_ctrl_seq.sv
// Bench for ecc_ctrl_seq: five instances (ladder program plus diagnostic ROMs)
// driven in lock-step and checked cycle by cycle against a microprogram interpreter.
module tb_ecc_ctrl_seq;

  localparam int N_INST = 5;
  localparam int DEPTH  = 4096;
  localparam int KW [N_INST] = '{233, 233, 4, 4, 2};
  localparam int AW [N_INST] = '{8, 8, 8, 8, 4};

  typedef struct packed {
    int          op;
    int          arg;
    logic [32:0] cw;
  } tb_word_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [232:0] key;
  logic [32:0]  cw_o   [N_INST];
  logic         busy_o [N_INST];
  logic         done_o [N_INST];

  logic [32:0]  exp_cw   [N_INST][DEPTH];
  logic         exp_busy [N_INST][DEPTH];
  logic         exp_done [N_INST][DEPTH];
  int           exp_len  [N_INST];
  int           exp_pos  [N_INST];
  bit           idle_prev[N_INST];
  logic [32:0]  cur_cw   [N_INST];
  logic         cur_busy [N_INST];
  logic         cur_done [N_INST];

  int n_assert;
  int n_fail;
  int cycle;

  ecc_ctrl_seq #(.KEY_W(233), .UPC_W(8), .ROM_IMAGE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key[232:0]),
    .cword(cw_o[0]), .busy(busy_o[0]), .done(done_o[0]));
  ecc_ctrl_seq #(.KEY_W(233), .UPC_W(8), .ROM_IMAGE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key[232:0]),
    .cword(cw_o[1]), .busy(busy_o[1]), .done(done_o[1]));
  ecc_ctrl_seq #(.KEY_W(4), .UPC_W(8), .ROM_IMAGE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key[3:0]),
    .cword(cw_o[2]), .busy(busy_o[2]), .done(done_o[2]));
  ecc_ctrl_seq #(.KEY_W(4), .UPC_W(8), .ROM_IMAGE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key[3:0]),
    .cword(cw_o[3]), .busy(busy_o[3]), .done(done_o[3]));
  ecc_ctrl_seq #(.KEY_W(2), .UPC_W(4), .ROM_IMAGE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key[1:0]),
    .cword(cw_o[4]), .busy(busy_o[4]), .done(done_o[4]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic tb_word_t mk(input int op, input int arg, input logic [32:0] cw);
    tb_word_t w;
    w.op = op; w.arg = arg; w.cw = cw;
    return w;
  endfunction

  // The bench's own copy of each program, as written in the design notes.
  function automatic tb_word_t rom_lookup(input int img, input int addr);
    tb_word_t w;
    w = mk(0, 0, 33'h0);
    case (img)
      0: case (addr)
        0: w = mk(0, 0, 33'h0_0000_0013);
        1: w = mk(1, 5, 33'h0_0000_0100);
        2: w = mk(3, 3, 33'h0_0004_2001);
        3: w = mk(2, 1, 33'h0_0000_0200);
        4: w = mk(4, 0, 33'h0);
        5: w = mk(3, 3, 33'h0_0008_1002);
        6: w = mk(2, 1, 33'h0_0000_0400);
        7: w = mk(0, 0, 33'h1_0000_0800);
        8: w = mk(4, 0, 33'h0);
        default: ;
      endcase
      1: case (addr)
        0: w = mk(0, 0, 33'h1);
        1: w = mk(0, 0, 33'h2);
        2: w = mk(0, 0, 33'h3);
        3: w = mk(4, 0, 33'h0);
        default: ;
      endcase
      2: case (addr)
        0:  w = mk(1, 10, 33'h10);
        1:  w = mk(0, 0, 33'h11);
        2:  w = mk(4, 0, 33'h12);
        10: w = mk(0, 0, 33'h1A);
        11: w = mk(4, 0, 33'h1B);
        default: ;
      endcase
      3: case (addr)
        0: w = mk(0, 0, 33'h20);
        1: w = mk(2, 0, 33'h21);
        2: w = mk(4, 0, 33'h0);
        default: ;
      endcase
      default: case (addr)
        0:  w = mk(3, 6, 33'h155);
        1:  w = mk(5, 0, 33'h1_0000_0001);
        2:  w = mk(6, 0, 33'h0_AAAA_5555);
        3:  w = mk(7, 0, 33'h3);
        4:  w = mk(0, 0, 33'h4);
        5:  w = mk(0, 0, 33'h5);
        6:  w = mk(2, 15, 33'h6);
        7:  w = mk(4, 0, 33'h1_FFFF_FFFF);
        15: w = mk(0, 0, 33'h1F);
        default: ;
      endcase
    endcase
    return w;
  endfunction

  task automatic put(input int i, input logic [32:0] c, input logic b, input logic d);
    if (exp_len[i] < DEPTH) begin
      exp_cw[i][exp_len[i]]   = c;
      exp_busy[i][exp_len[i]] = b;
      exp_done[i][exp_len[i]] = d;
      exp_len[i]++;
    end
  endtask

  // Expands a whole run into the list of per-cycle outputs, RUN cycles then FIN.
  task automatic load_trace(input int i, input logic [232:0] k);
    int pc, bi, span;
    tb_word_t w;
    span = 1 << AW[i];
    pc = 0;
    bi = KW[i] - 1;
    exp_len[i] = 0;
    exp_pos[i] = 0;
    for (int g = 0; g < DEPTH; g++) begin
      w = rom_lookup(i, pc);
      if (w.op == 4) begin
        put(i, 33'h0, 1'b1, 1'b0);
        put(i, 33'h0, 1'b0, 1'b1);
        break;
      end
      if (w.op == 3) begin
        for (int r = 0; r <= w.arg; r++) put(i, w.cw, 1'b1, 1'b0);
        pc = (pc + 1) % span;
      end else begin
        put(i, w.cw, 1'b1, 1'b0);
        if (w.op == 1)
          pc = k[bi] ? (w.arg % span) : ((pc + 1) % span);
        else if (w.op == 2 && bi != 0) begin
          bi = bi - 1;
          pc = w.arg % span;
        end else
          pc = (pc + 1) % span;
      end
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < N_INST; i++) begin
      exp_len[i] = 0;
      exp_pos[i] = 0;
      idle_prev[i] = 1'b1;
      cur_cw[i] = '0;
      cur_busy[i] = 1'b0;
      cur_done[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      clear_model();
      return;
    end
    for (int i = 0; i < N_INST; i++) begin
      if (idle_prev[i] && start) load_trace(i, key);
      if (exp_pos[i] < exp_len[i]) begin
        cur_cw[i]   = exp_cw[i][exp_pos[i]];
        cur_busy[i] = exp_busy[i][exp_pos[i]];
        cur_done[i] = exp_done[i][exp_pos[i]];
        exp_pos[i]++;
        idle_prev[i] = 1'b0;
      end else begin
        cur_cw[i]   = '0;
        cur_busy[i] = 1'b0;
        cur_done[i] = 1'b0;
        idle_prev[i] = 1'b1;
      end
    end
  endtask

  task automatic checkOutput();
    for (int i = 0; i < N_INST; i++) begin
      n_assert++;
      assert (cw_o[i] === cur_cw[i]) else begin
        n_fail++;
        $error("[TB] FAIL cword inst%0d cycle %0d: got %h want %h", i, cycle, cw_o[i], cur_cw[i]);
      end
      n_assert++;
      assert (busy_o[i] === cur_busy[i]) else begin
        n_fail++;
        $error("[TB] FAIL busy inst%0d cycle %0d: got %b want %b", i, cycle, busy_o[i], cur_busy[i]);
      end
      n_assert++;
      assert (done_o[i] === cur_done[i]) else begin
        n_fail++;
        $error("[TB] FAIL done inst%0d cycle %0d: got %b want %b", i, cycle, done_o[i], cur_done[i]);
      end
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [232:0] k);
    start = s;
    key = k;
    @(posedge clk);
    cycle++;
    model_step();
    #1;
    checkOutput();
  endtask

  function automatic logic [232:0] rand_key();
    logic [255:0] w;
    for (int j = 0; j < 8; j++) w[j*32 +: 32] = $urandom;
    return w[232:0];
  endfunction

  function automatic bit all_idle();
    for (int i = 0; i < N_INST; i++)
      if (exp_pos[i] < exp_len[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic settle(input logic [232:0] k);
    for (int n = 0; n < 3000 && !all_idle(); n++) applyStimulus(1'b0, k);
    applyStimulus(1'b0, k);
    n_assert++;
    assert (all_idle()) else begin
      n_fail++;
      $error("[TB] FAIL settle: instances still running after 3000 cycles, got busy want idle");
    end
  endtask

  // Start requests and key changes while instances are running must be ignored.
  task automatic noisy(input int cycles);
    for (int n = 0; n < cycles; n++)
      applyStimulus(($urandom % 5) == 0, rand_key());
  endtask

  logic [232:0] k;

  initial begin
    n_assert = 0;
    n_fail = 0;
    cycle = 0;
    rst_n = 1'b0;
    start = 1'b0;
    key = '0;
    clear_model();

    $display("[TB] reset state");
    applyStimulus(1'b0, '0);
    applyStimulus(1'b0, '0);
    rst_n = 1'b1;
    applyStimulus(1'b0, '0);
    applyStimulus(1'b0, '0);

    $display("[TB] branch taken, key low nibble 1010");
    k = rand_key();
    k[3:0] = 4'b1010;
    applyStimulus(1'b1, k);
    settle(k);

    $display("[TB] branch not taken, key low nibble 0010, busy-start noise");
    k = rand_key();
    k[3:0] = 4'b0010;
    applyStimulus(1'b1, k);
    noisy(40);
    settle(rand_key());

    $display("[TB] async reset in the middle of a run");
    k = rand_key();
    applyStimulus(1'b1, k);
    repeat (11) applyStimulus(1'b0, k);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < N_INST; i++) begin
      n_assert++;
      assert (cw_o[i] === 33'h0 && busy_o[i] === 1'b0 && done_o[i] === 1'b0) else begin
        n_fail++;
        $error("[TB] FAIL async_reset inst%0d: got cword %h busy %b done %b want all zero",
               i, cw_o[i], busy_o[i], done_o[i]);
      end
    end
    clear_model();
    applyStimulus(1'b0, k);
    rst_n = 1'b1;
    repeat (4) applyStimulus(1'b0, rand_key());

    $display("[TB] random rounds");
    for (int r = 0; r < 3; r++) begin
      k = rand_key();
      applyStimulus(1'b1, k);
      noisy(60);
      settle(rand_key());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ecc_ctrl_seq.md
ECC_CTRL_SEQ -- requirements
Module: ecc_ctrl_seq

Interface
REQ-001 SHALL have parameter KEY_W, default 233, scalar width in bits.
REQ-002 SHALL have parameter UPC_W, default 8, microcode address width.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to run a scalar multiplication.
REQ-006 SHALL have port key  input  KEY_W  scalar; sampled only on an accepted start.
REQ-007 SHALL have port cword  output  33  control word [32:0] driven to the register bank; field layout per the bank.
REQ-008 SHALL have port busy  output  1  high from the cycle after accepted start until done.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-010 SHALL implement FSM states IDLE, RUN, FIN; reset state IDLE.
REQ-011 SHALL accept start only in IDLE; start in RUN/FIN is ignored, no effect.
REQ-012 SHALL on accepted start: latch key into key_r, set upc=0, bit_idx=KEY_W-1, rep_cnt=0, enter RUN next cycle.
REQ-013 SHALL fetch a 44-bit microword from the ROM at upc: [32:0] cw, [35:33] op, [43:36] arg.
REQ-014 SHALL drive cword = cw combinationally from the current microword while in RUN, except op HALT; cword SHALL be all-zero in IDLE, FIN and on HALT (no bank write-enable outside RUN).
REQ-015 SHALL execute op NEXT(0): upc <= upc+1.
REQ-016 SHALL execute op BR_KEY(1): upc <= arg if key_r[bit_idx]==1, else upc+1.
REQ-017 SHALL execute op LOOP(2): if bit_idx!=0 then bit_idx <= bit_idx-1, upc <= arg; else upc <= upc+1, bit_idx unchanged.
REQ-018 SHALL execute op REP(3): hold upc and re-issue the same cw for arg+1 consecutive cycles total (rep_cnt counts 0..arg), then upc+1 and rep_cnt <= 0; arg=0 behaves as NEXT.
REQ-019 SHALL execute op HALT(4): enter FIN next cycle; upc unchanged.
REQ-020 SHALL treat op codes 5-7 as NEXT.
REQ-021 SHALL in FIN assert done for exactly one cycle, then return to IDLE; busy low in FIN.
REQ-022 SHALL wrap upc modulo 2^UPC_W on upc+1 from the top address.
REQ-023 SHALL keep key_r stable for the whole RUN; key changes during RUN are ignored.
REQ-024 SHALL have latency from accepted start to first non-zero cword of exactly 1 cycle (cword from ROM[0] in first RUN cycle).

Reset
REQ-025 SHALL on rst_n low, at any time including mid-RUN, immediately force state IDLE, cword=0, busy=0, done=0, upc=0, bit_idx=0, rep_cnt=0, key_r=0.
REQ-026 SHALL resume only on a new start after rst_n deasserts; no pending request survives reset.

Structure
REQ-027 SHALL place op encodings, microword field positions, and the 44-bit word width in a shared package ecc_ctrl_pkg.
REQ-028 SHALL instantiate one sub-module ecc_ucode_rom (input addr UPC_W, output data 44, combinational) holding the microprogram; the bench SHALL be able to substitute a test ROM with identical ports.
REQ-029 SHALL size bit_idx as ceil(log2(KEY_W)) bits and rep_cnt as 8 bits.

Verification
REQ-030 Reset: rst_n low mid-RUN at upc=5 -> same cycle cword=0, busy=0; after release, no activity until start.
REQ-031 Straight line: test ROM NEXT x3 (cw=1,2,3) then HALT, start -> cword 1,2,3,0 on consecutive cycles, done pulse one cycle after HALT cycle, busy high 4 cycles.
REQ-032 Branch: KEY_W=4, key=4'b1010, ROM0 BR_KEY arg=10 -> upc=10 next cycle (bit3=1); key=4'b0010 -> upc=1.
REQ-033 Loop: KEY_W=4, ROM0 NEXT, ROM1 LOOP arg=0, ROM2 HALT -> ROM1 issued 4 times total, bit_idx 3,2,1,0, then HALT; done after 9 RUN cycles.
REQ-034 Repeat: ROM0 REP arg=6 cw=0x155 -> cword=0x155 for exactly 7 cycles, then ROM1 contents.
REQ-035 Busy start: start pulsed during RUN and key changed -> sequence and BR_KEY outcomes unchanged, single done pulse.
